hazard_forward_ctrl: RTL and testbench

//  Parametrised successor to the 2-stage combinational forwarding selector. Tracks in-flight destination tags
//  for an EX slot plus FWD_STAGES downstream stages internally. Generates per-source forwarding selects for the
//  EX-stage instruction and a load-use stall for the ID-stage instruction. Supports N read ports and

---
 rtl/hazard_forward_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and load-use interlock controller.
// Tracks destination tags for the EX slot and FWD_STAGES downstream stages.
module hazard_forward_ctrl #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int AW         = 5,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [NUM_SRC*AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_reg_write,
    input  logic                     id_is_load,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic                  ex_v_q, ex_v_d;
    logic [NUM_SRC*AW-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]    ex_used_q, ex_used_d;
    logic [AW-1:0]         ex_rd_q, ex_rd_d;
    logic                  ex_we_q, ex_we_d;
    logic                  ex_ld_q, ex_ld_d;

    logic [FWD_STAGES:1]         tag_v_q, tag_v_d;
    logic [FWD_STAGES:1][AW-1:0] tag_rd_q, tag_rd_d;
    logic [FWD_STAGES:1]         tag_we_q, tag_we_d;
    logic [FWD_STAGES:1]         tag_ld_q, tag_ld_d;

    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic                     stall_c;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;

    // x0 is hardwired, so a write to it never produces a forwardable value
    function automatic logic live(input logic v, input logic we, input logic [AW-1:0] rd);
        return v & we & (rd != '0);
    endfunction

    always_comb begin
        stall_c = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid && !flush && id_rs_used[i]) begin
                if (LOAD_STAGE > 1 && live(ex_v_q, ex_we_q, ex_rd_q) && ex_ld_q &&
                    ex_rd_q == id_rs[i*AW +: AW])
                    stall_c = 1'b1;
                for (int k = 1; k <= FWD_STAGES; k++) begin
                    if (k + 1 < LOAD_STAGE && live(tag_v_q[k], tag_we_q[k], tag_rd_q[k]) &&
                        tag_ld_q[k] && tag_rd_q[k] == id_rs[i*AW +: AW])
                        stall_c = 1'b1;
                end
            end
        end
    end

    // Scan oldest to youngest so the youngest matching stage overwrites the select
    always_comb begin
        fwd_sel_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (ex_v_q && ex_used_q[i] && live(tag_v_q[k], tag_we_q[k], tag_rd_q[k]) &&
                    tag_rd_q[k] == ex_rs_q[i*AW +: AW] && (!tag_ld_q[k] || k >= LOAD_STAGE))
                    fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
        end
    end

    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rs_d     = ex_rs_q;
        ex_used_d   = ex_used_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_ld_d     = ex_ld_q;
        tag_v_d     = tag_v_q;
        tag_rd_d    = tag_rd_q;
        tag_we_d    = tag_we_q;
        tag_ld_d    = tag_ld_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold) begin
            tag_v_d[1]  = ex_v_q;
            tag_rd_d[1] = ex_rd_q;
            tag_we_d[1] = ex_we_q;
            tag_ld_d[1] = ex_ld_q;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_rd_d[k] = tag_rd_q[k-1];
                tag_we_d[k] = tag_we_q[k-1];
                tag_ld_d[k] = tag_ld_q[k-1];
            end
            ex_v_d    = id_valid & ~stall_c & ~flush;
            ex_rs_d   = id_rs;
            ex_used_d = id_rs_used;
            ex_rd_d   = id_rd;
            ex_we_d   = id_reg_write;
            ex_ld_d   = id_is_load;
            if (stall_c && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_rs_q     <= '0;
            ex_used_q   <= '0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            tag_v_q     <= '0;
            tag_rd_q    <= '0;
            tag_we_q    <= '0;
            tag_ld_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rs_q     <= ex_rs_d;
            ex_used_q   <= ex_used_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            tag_v_q     <= tag_v_d;
            tag_rd_q    <= tag_rd_d;
            tag_we_q    <= tag_we_d;
            tag_ld_q    <= tag_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_c;
    assign stall     = stall_c;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench for hazard_forward_ctrl; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic        id_is_load = 1'b0;

    logic [3:0]  fwd_sel, sat_fwd_sel;
    logic        stall, sat_stall;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_stall_cnt;

    hazard_forward_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    hazard_forward_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .fwd_sel(sat_fwd_sel), .stall(sat_stall), .stall_cnt(sat_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  s1;
        logic [1:0]  s0;
        logic        st;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_cnt  = '0;
    logic [1:0]  exp_cnt2 = '0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (fwd_sel !== {mon_e.s1, mon_e.s0} || stall !== mon_e.st || stall_cnt !== mon_e.cnt ||
                sat_fwd_sel !== {mon_e.s1, mon_e.s0} || sat_stall !== mon_e.st ||
                sat_stall_cnt !== mon_e.cnt2) begin
                n_miss++;
                $display("FAIL vec%0d: got fwd_sel=%h stall=%b cnt=%0d sat_cnt=%0d, want fwd_sel=%h stall=%b cnt=%0d sat_cnt=%0d",
                         n_vec, fwd_sel, stall, stall_cnt, sat_stall_cnt,
                         {mon_e.s1, mon_e.s0}, mon_e.st, mon_e.cnt, mon_e.cnt2);
            end
        end
    end

    task automatic step(input logic rst, input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [4:0] rd, input logic we, input logic ld,
                        input logic hd, input logic fl,
                        input logic [1:0] e0, input logic [1:0] e1, input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        id_valid     = v;
        id_rs        = {r1, r0};
        id_rs_used   = used;
        id_rd        = rd;
        id_reg_write = we;
        id_is_load   = ld;
        hold         = hd;
        flush        = fl;
        if (!rst) begin
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end
        e.s0 = e0; e.s1 = e1; e.st = est; e.cnt = exp_cnt; e.cnt2 = exp_cnt2;
        sb.push_back(e);
        if (rst && est && !hd) begin
            if (exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
        end
    endtask

    task automatic idle(input logic [1:0] e0, input logic [1:0] e1, input logic est);
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, e0, e1, est);
    endtask

    initial begin
        // reset with a would-be hazard on the ID inputs
        step(0, 1, 3, 3, 2'b11, 3, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 3, 3, 2'b11, 3, 1, 1, 0, 0, 0, 0, 0);
        // EX/MEM forward: add x5 then sub x5
        step(1, 1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 6, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        // youngest writer of x7 wins, older one reached through MEM/WB
        step(1, 1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 9, 2'b11, 10, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 7, 2'b11, 11, 1, 0, 0, 0, 1, 0, 0);
        idle(0, 2, 0);
        idle(0, 0, 0);
        // load-use x3 on src1
        step(1, 1, 1, 0, 2'b01, 3, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 2, 3, 2'b11, 12, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 2, 3, 2'b11, 12, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 2, 0);
        // x0 load and unused source
        step(1, 1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 2'b11, 13, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 4, 2'b01, 14, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // hold during load-use: stall persists, counter and tags frozen
        step(1, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++)
            step(1, 1, 6, 0, 2'b01, 15, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 6, 0, 2'b01, 15, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 6, 0, 2'b01, 15, 1, 0, 0, 0, 0, 0, 0);
        idle(2, 0, 0);
        // flush with load-use hazard; a later reader of x16 must not see the killed instr
        step(1, 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 2'b01, 16, 1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 16, 0, 2'b01, 17, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // two sources resolved from different stages
        step(1, 1, 0, 0, 2'b00, 20, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 2'b00, 21, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 21, 20, 2'b11, 22, 1, 0, 0, 0, 0, 0, 0);
        idle(1, 2, 0);
        // reset with live forward and load-use pending, then no stale state
        step(1, 1, 22, 0, 2'b01, 24, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 24, 0, 2'b01, 25, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 24, 0, 2'b01, 25, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 24, 0, 2'b01, 25, 1, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        // five load-use stalls: 2-bit counter saturates at 3
        for (int n = 0; n < 5; n++) begin
            step(1, 1, 0, 0, 2'b00, 26, 1, 1, 0, 0, (n > 0) ? 2'd2 : 2'd0, 0, 0);
            step(1, 1, 26, 0, 2'b01, 27, 1, 0, 0, 0, 0, 0, 1);
            step(1, 1, 26, 0, 2'b01, 27, 1, 0, 0, 0, 0, 0, 0);
        end
        idle(2, 0, 0);
        idle(0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
